mm_controller_param: RTL and testbench
======================================

// Module: mm_controller_param
// PURPOSE
//  Parametrised matrix-multiply controller: computes C = A x B for N x N matrices held in external sync SRAMs.
//  Successor to the fixed 32x32/8-bit controller; adds configurable size, lanes and read latency, signed mode and abort.
//  Every memory-side output is registered inside the block, so no separate timing wrapper is needed.
//  Sits between the A/B operand memories and the C result memory; a host drives start and watches done.
// PARAMETERS
//  N       32  matrix dimension (power of 2, >= LANES)
//  DW      8   operand element width
//  LANES   4   B elements per B word = parallel MACs (power of 2)
//  RD_LAT  1   SRAM read latency, cycles from registered address to valid rdata
//  ACCW    2*DW+$clog2(N) = 21   accumulator / C word width
//  AW_A=AW_C=$clog2(N*N); AW_B=$clog2(N*N/LANES)  (derived localparams, 10/10/8 at defaults)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous, active-high reset
//  start      in   1         begin run; sampled only in IDLE
//  abort      in   1         sync cancel of an active run
//  signed_md  in   1         1 = two's-complement operands; sampled with start
//  a_rdata    in   DW        A[i][k] read data
//  b_rdata    in   DW*LANES  B[k][j..j+LANES-1]; lane 0 in LSBs
//  address_a  out  AW_A      i*N+k
//  address_b  out  AW_B      k*(N/LANES)+j/LANES
//  nce        out  1         A/B read enable, active low
//  nwrt       out  1         A/B write enable, active low; held 1 (never write)
//  address_c  out  AW_C      i*N+j
//  C_in       out  ACCW      C write data
//  nce_out    out  1         C enable, active low
//  nwrt_out   out  1         C write enable, active low
//  busy       out  1         high from first cycle after start accepted until done/abort
//  done       out  1         one-cycle pulse after last C write
// BEHAVIOUR
//  Reset (async, immediate, no clock needed): state IDLE; all addresses 0, C_in 0, nce/nwrt/nce_out/nwrt_out 1,
//   busy 0, done 0; accumulators and a_q/b_q input registers cleared.
//  FSM: IDLE -> FETCH -> DRAIN -> WRITE -> (next block: FETCH | last: DONE) -> IDLE.
//   IDLE : start=1 latches signed_md, clears i, jb=0 -> FETCH.
//   FETCH: N cycles, k=0..N-1; nce=0, drive address_a/address_b per above.
//   DRAIN: RD_LAT+1 cycles; rdata captured into a_q/b_q, last MACs complete; nce=1.
//   WRITE: LANES cycles; lane L -> address_c=i*N+jb*LANES+L, nce_out=nwrt_out=0.
//   Block order: jb increments fastest, then i; after i=N-1, jb=N/LANES-1 -> DONE.
//   DONE : done=1 for exactly 1 cycle, busy=0 -> IDLE.
//  Datapath: a_q/b_q registered on every edge; accumulator L cleared when the k=0 product enters,
//   acc_L += a_q * b_q[L] (sign-extended when signed_md, else zero-extended), result truncated mod 2^ACCW.
//  Cycles per block = N + RD_LAT + 1 + LANES; total = (N*N/LANES)*block + 1 (DONE).
//  start while busy: ignored. start held high through DONE: new run begins the cycle after DONE.
//  abort=1 in any non-IDLE state: next edge -> IDLE; nce/nce_out/nwrt_out 1; no done; no further C writes.
//   abort and start together in IDLE: abort wins (stay IDLE).
//  Corner: LANES == N gives one block per row; RD_LAT=0 is legal (combinational SRAM model).
// STRUCTURE
//  mm_pkg: state encoding localparams, clog2 function, derived-width macros shared with the C-memory model.
//  Sub-module mm_mac_lane (DW, ACCW): one signed/unsigned MAC with clear; instantiated LANES times via generate.
//  Top holds the FSM, counters (i, jb, k, drain, lane), address generation and output registers.
// TESTING
//  T1 identity: N=4,LANES=2,RD_LAT=1, A=I, B[k][j]=4k+j -> C==B; done pulses once, 65 cycles after start accepted.
//  T2 max unsigned (defaults): all A,B=255 -> every C = 2080800 (21'h1FC020), 1024 C writes, no wrap.
//  T3 signed: A=-128,B=-128 -> C=524288; A=-1,B=1 -> C=21'h1FFFE0 (-32); same data signed_md=0 -> 8160 per C.
//  T4 handshake: start pulsed mid-run -> ignored; start held high -> back-to-back runs, done 1 cycle each.
//  T5 abort at FETCH cycle 20 -> IDLE next edge, no done, no writes after; fresh start gives correct T1 result.
//  T6 rst raised between edges in WRITE -> outputs at reset values before next clk edge; rerun after release is correct.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared state encoding and width helpers for the parametrised matrix-multiply controller.
package mm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } mm_state_t;

  // Counter width that stays legal (>= 1 bit) when the count range collapses to one value.
  function automatic int cnt_width(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/mm_mac_lane.sv
// One multiply-accumulate lane: clear-on-first-product, signed or unsigned operands,
// result wraps modulo 2^ACCW. The combinational next value is exported for the C write path.
module mm_mac_lane #(
  parameter int DW   = 8,
  parameter int ACCW = 21
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic            signed_md,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [ACCW-1:0] sum
);

  logic [ACCW-1:0] acc_reg;
  logic [ACCW-1:0] a_ext;
  logic [ACCW-1:0] b_ext;
  logic [ACCW-1:0] prod;

  always_comb begin
    a_ext = signed_md ? {{(ACCW-DW){a[DW-1]}}, a} : {{(ACCW-DW){1'b0}}, a};
    b_ext = signed_md ? {{(ACCW-DW){b[DW-1]}}, b} : {{(ACCW-DW){1'b0}}, b};
    prod  = a_ext * b_ext;
    sum   = acc_reg;
    if (en) begin
      sum = clr ? prod : acc_reg + prod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= sum;
    end
  end

endmodule

// File: rtl/mm_controller_param.sv
// Matrix-multiply controller C = A x B over external sync SRAMs; LANES columns of C are
// produced per block, and every memory-side output comes straight from a flop.
module mm_controller_param
  import mm_pkg::*;
#(
  parameter int N      = 32,
  parameter int DW     = 8,
  parameter int LANES  = 4,
  parameter int RD_LAT = 1,
  parameter int ACCW   = acc_width(DW, N),
  localparam int AW_A  = $clog2(N*N),
  localparam int AW_B  = $clog2(N*N/LANES),
  localparam int AW_C  = $clog2(N*N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  signed_md,
  input  logic [DW-1:0]         a_rdata,
  input  logic [DW*LANES-1:0]   b_rdata,
  output logic [AW_A-1:0]       address_a,
  output logic [AW_B-1:0]       address_b,
  output logic                  nce,
  output logic                  nwrt,
  output logic [AW_C-1:0]       address_c,
  output logic [ACCW-1:0]       C_in,
  output logic                  nce_out,
  output logic                  nwrt_out,
  output logic                  busy,
  output logic                  done
);

  localparam int NB  = N / LANES;
  localparam int KW  = cnt_width(N);
  localparam int JBW = cnt_width(NB);
  localparam int LW  = cnt_width(LANES);
  localparam int DCW = cnt_width(RD_LAT + 1);

  mm_state_t       state_reg, state_next;
  logic [KW-1:0]   i_reg, i_next;
  logic [KW-1:0]   k_reg, k_next;
  logic [JBW-1:0]  jb_reg, jb_next;
  logic [LW-1:0]   lane_reg, lane_next;
  logic [DCW-1:0]  dcnt_reg, dcnt_next;
  logic            signed_reg, signed_next;

  logic [DW-1:0]       a_q;
  logic [DW*LANES-1:0] b_q;
  logic [RD_LAT:0]     v_pipe;
  logic [RD_LAT:0]     f_pipe;
  logic                fetch_v;
  logic                fetch_first;

  logic [ACCW-1:0] mac_sum [LANES];
  logic [ACCW-1:0] c_sel;
  logic [AW_A-1:0] addr_a_next;
  logic [AW_B-1:0] addr_b_next;
  logic [AW_C-1:0] addr_c_next;
  logic [ACCW-1:0] c_in_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      i_reg      <= '0;
      k_reg      <= '0;
      jb_reg     <= '0;
      lane_reg   <= '0;
      dcnt_reg   <= '0;
      signed_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      i_reg      <= i_next;
      k_reg      <= k_next;
      jb_reg     <= jb_next;
      lane_reg   <= lane_next;
      dcnt_reg   <= dcnt_next;
      signed_reg <= signed_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    i_next      = i_reg;
    k_next      = k_reg;
    jb_next     = jb_reg;
    lane_next   = lane_reg;
    dcnt_next   = dcnt_reg;
    signed_next = signed_reg;
    if (state_reg != ST_IDLE && abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && !abort) begin
            state_next  = ST_FETCH;
            signed_next = signed_md;
            i_next      = '0;
            jb_next     = '0;
            k_next      = '0;
          end
        end
        ST_FETCH: begin
          if (k_reg == KW'(N-1)) begin
            state_next = ST_DRAIN;
            dcnt_next  = '0;
          end else begin
            k_next = k_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (dcnt_reg == DCW'(RD_LAT)) begin
            state_next = ST_WRITE;
            lane_next  = '0;
          end else begin
            dcnt_next = dcnt_reg + 1'b1;
          end
        end
        ST_WRITE: begin
          if (lane_reg == LW'(LANES-1)) begin
            k_next = '0;
            if (jb_reg == JBW'(NB-1)) begin
              if (i_reg == KW'(N-1)) begin
                state_next = ST_DONE;
              end else begin
                state_next = ST_FETCH;
                jb_next    = '0;
                i_next     = i_reg + 1'b1;
              end
            end else begin
              state_next = ST_FETCH;
              jb_next    = jb_reg + 1'b1;
            end
          end else begin
            lane_next = lane_reg + 1'b1;
          end
        end
        ST_DONE:  state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Valid/first tags travel alongside the read data so each product meets its k index.
  assign fetch_v     = (state_reg == ST_FETCH) && !abort;
  assign fetch_first = fetch_v && (k_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      v_pipe <= '0;
      f_pipe <= '0;
    end else begin
      a_q       <= a_rdata;
      b_q       <= b_rdata;
      v_pipe[0] <= fetch_v;
      f_pipe[0] <= fetch_first;
      for (int s = 1; s <= RD_LAT; s++) begin
        v_pipe[s] <= v_pipe[s-1];
        f_pipe[s] <= f_pipe[s-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      mm_mac_lane #(
        .DW   (DW),
        .ACCW (ACCW)
      ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .en        (v_pipe[RD_LAT]),
        .clr       (f_pipe[RD_LAT]),
        .signed_md (signed_reg),
        .a         (a_q),
        .b         (b_q[gi*DW +: DW]),
        .sum       (mac_sum[gi])
      );
    end
  endgenerate

  // The last product lands on the edge that enters WRITE, so C_in samples the MAC next value.
  always_comb begin
    c_sel = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_next == LW'(l)) begin
        c_sel = mac_sum[l];
      end
    end
  end

  always_comb begin
    addr_a_next = address_a;
    addr_b_next = address_b;
    addr_c_next = address_c;
    c_in_next   = C_in;
    if (state_next == ST_FETCH) begin
      addr_a_next = AW_A'(i_next) * AW_A'(N) + AW_A'(k_next);
      addr_b_next = AW_B'(k_next) * AW_B'(NB) + AW_B'(jb_next);
    end
    if (state_next == ST_WRITE) begin
      addr_c_next = AW_C'(i_next) * AW_C'(N) + AW_C'(jb_next) * AW_C'(LANES) + AW_C'(lane_next);
      c_in_next   = c_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address_a <= '0;
      address_b <= '0;
      address_c <= '0;
      C_in      <= '0;
      nce       <= 1'b1;
      nwrt      <= 1'b1;
      nce_out   <= 1'b1;
      nwrt_out  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      address_a <= addr_a_next;
      address_b <= addr_b_next;
      address_c <= addr_c_next;
      C_in      <= c_in_next;
      nce       <= (state_next != ST_FETCH);
      nwrt      <= 1'b1;
      nce_out   <= (state_next != ST_WRITE);
      nwrt_out  <= (state_next != ST_WRITE);
      busy      <= (state_next == ST_FETCH) || (state_next == ST_DRAIN) || (state_next == ST_WRITE);
      done      <= (state_next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_mm_controller_param.sv
// Directed bench for mm_controller_param at N=4, LANES=2, RD_LAT=1 (ACCW=18) with SRAM models.
module tb_mm_controller_param;

  localparam int N = 4, DW = 8, LANES = 2, RD_LAT = 1;
  localparam int ACCW = 18, AW_A = 4, AW_B = 3, AW_C = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start, abort, signed_md;
  logic [DW-1:0]       a_rdata;
  logic [DW*LANES-1:0] b_rdata;
  logic [AW_A-1:0]     address_a;
  logic [AW_B-1:0]     address_b;
  logic [AW_C-1:0]     address_c;
  logic [ACCW-1:0]     C_in;
  logic nce, nwrt, nce_out, nwrt_out, busy, done;

  always #5 clk = ~clk;

  mm_controller_param #(.N(N), .DW(DW), .LANES(LANES), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .signed_md(signed_md),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .address_a(address_a), .address_b(address_b),
    .nce(nce), .nwrt(nwrt), .address_c(address_c), .C_in(C_in),
    .nce_out(nce_out), .nwrt_out(nwrt_out), .busy(busy), .done(done)
  );

  logic [DW-1:0]       amem [N*N];
  logic [DW*LANES-1:0] bmem [N*N/LANES];
  logic [ACCW-1:0]     cmem [N*N];
  int                  cmem_run [N*N];
  int                  run_id = 0;
  int                  wr_cnt = 0;

  // Sync SRAM models: one-cycle read, C write tagged with the run that produced it.
  always @(posedge clk) begin
    a_rdata <= amem[address_a];
    b_rdata <= bmem[address_b];
    if (!nce_out && !nwrt_out) begin
      cmem[address_c]     <= C_in;
      cmem_run[address_c] <= run_id;
      wr_cnt              <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic       a_id;
    logic [7:0] a_val;
    logic       b_ramp;
    logic [7:0] b_val;
    logic       sgn;
    int         base;
    int         ei;
    int         ej;
  } vec_t;

  vec_t vecs [8];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fill(input vec_t v);
    logic [7:0] bval;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        amem[r*N+c] = v.a_id ? ((r == c) ? 8'd1 : 8'd0) : v.a_val;
        bval = v.b_ramp ? 8'(4*r + c) : v.b_val;
        bmem[r*(N/LANES) + c/LANES][(c%LANES)*DW +: DW] = bval;
      end
    end
  endtask

  task automatic check_cells(input string tag, input vec_t v);
    logic [ACCW-1:0] expv;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        expv = ACCW'(v.base + r*v.ei + c*v.ej);
        check($sformatf("%s c[%0d][%0d]", tag, r, c),
              {13'd0, (cmem_run[r*N+c] == run_id), cmem[r*N+c]}, {13'd0, 1'b1, expv});
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " addr"}, {21'd0, address_a, address_b, address_c}, 32'd0);
    check({tag, " c_in"}, {14'd0, C_in}, 32'd0);
    check({tag, " ctl"}, {26'd0, nce, nwrt, nce_out, nwrt_out, busy, done}, 32'b111100);
  endtask

  // Runs one job; optional single-cycle start pulse at sample pulse_at while busy.
  task automatic run_once(input logic sgn, input int pulse_at, output int lat, output int ndone);
    bit seen;
    run_id++;
    @(negedge clk);
    signed_md = sgn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; ndone = 0; seen = 0;
    for (int c = 0; c < 400; c++) begin
      if (busy || done) lat++;
      if (done) begin
        ndone++;
        seen = 1;
      end else if (seen) begin
        break;
      end
      start = (c == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic full_run(input string tag, input vec_t v, input int pulse_at);
    int lat, nd, wbase;
    fill(v);
    wbase = wr_cnt;
    run_once(v.sgn, pulse_at, lat, nd);
    check({tag, " latency"}, lat, 65);
    check({tag, " done_pulses"}, nd, 1);
    check({tag, " writes"}, wr_cnt - wbase, 16);
    check_cells(tag, v);
  endtask

  initial begin
    int nd, gap, first_at, wbase;
    bit seen_done;

    vecs[0] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 0,      4, 1};   // A=I, B ramp -> C=B
    vecs[1] = '{1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 260100, 0, 0};   // max unsigned
    vecs[2] = '{1'b0, 8'h80, 1'b0, 8'h80, 1'b1, 65536,  0, 0};   // -128 * -128
    vecs[3] = '{1'b0, 8'hFF, 1'b0, 8'h01, 1'b1, -4,     0, 0};   // -1 * 1
    vecs[4] = '{1'b0, 8'hFF, 1'b0, 8'h01, 1'b0, 1020,   0, 0};   // same data unsigned
    vecs[5] = '{1'b0, 8'h01, 1'b1, 8'h00, 1'b0, 24,     0, 4};   // ones x ramp
    vecs[6] = '{1'b0, 8'hFF, 1'b1, 8'h00, 1'b1, -24,    0, -4};  // -1 x ramp, signed
    vecs[7] = '{1'b0, 8'h7F, 1'b0, 8'h80, 1'b1, -65024, 0, 0};   // 127 * -128

    start = 1'b0; abort = 1'b0; signed_md = 1'b0;
    fill(vecs[0]);
    #1 rst = 1'b1;
    #11;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 8; t++) begin
      full_run($sformatf("vec%0d", t), vecs[t], -1);
    end

    // start pulsed mid-run is ignored
    full_run("midstart", vecs[5], 20);

    // abort and start together in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", {30'd0, busy, nce}, 32'b01);

    // start held high: back-to-back runs
    fill(vecs[0]);
    run_id++;
    wbase = wr_cnt; nd = 0; gap = 0; first_at = 0;
    @(negedge clk);
    signed_md = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) begin
          first_at = c;
        end else begin
          gap = c - first_at;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("held done_count", nd, 2);
    check("held gap", gap, 66);
    repeat (80) @(negedge clk);
    check("held idle_after", {31'd0, busy}, 32'd0);
    check("held writes", wr_cnt - wbase, 32);
    check_cells("held", vecs[0]);

    // abort during FETCH of block 2
    fill(vecs[1]);
    run_id++;
    wbase = wr_cnt;
    @(negedge clk);
    signed_md = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    check("abort pre_fetch", {30'd0, busy, nce}, 32'b10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort ctl", {28'd0, busy, nce, nce_out, nwrt_out}, 32'b0111);
    check("abort writes_before", wr_cnt - wbase, 4);
    seen_done = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    check("abort quiet", {31'd0, seen_done}, 32'd0);
    check("abort writes_after", wr_cnt - wbase, 4);
    full_run("post_abort", vecs[0], -1);

    // asynchronous reset between edges during WRITE
    fill(vecs[0]);
    run_id++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 100; c++) begin
      if (!nce_out) begin
        seen_done = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst_mid write_reached", {31'd0, seen_done}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    full_run("post_rst", vecs[0], -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
